// File: rtl/nn_layer_sequencer.sv
// Address and strobe sequencer for the three-layer MNIST inference pass.
// Defining SEQ_CYCLE_CNT_EN adds the cycle_count port and its saturating counter.
module nn_layer_sequencer #(
  parameter int N_IN1  = 784,
  parameter int N_HID  = 20,
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              dp_ready,
  input  logic              act_done,
  output logic              busy,
  output logic              done,
  output logic [1:0]        layer,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_rd,
  output logic [ADDR_W-1:0] in_addr,
  output logic              in_rd,
  output logic [4:0]        hid_idx,
  output logic              mac_clear,
  output logic              mac_valid,
  output logic              bias_valid,
  output logic              act_start
`ifdef SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  // Weight/bias BRAM map: each layer's weight words are followed by its bias word.
  localparam logic [ADDR_W-1:0] WEIGHT_1 = '0;
  localparam logic [ADDR_W-1:0] BIAS_1   = ADDR_W'(N_IN1);
  localparam logic [ADDR_W-1:0] WEIGHT_2 = ADDR_W'(N_IN1 + 1);
  localparam logic [ADDR_W-1:0] BIAS_2   = ADDR_W'(N_IN1 + 1 + N_HID);
  localparam logic [ADDR_W-1:0] WEIGHT_3 = ADDR_W'(N_IN1 + 2 + N_HID);
  localparam logic [ADDR_W-1:0] BIAS_3   = ADDR_W'(N_IN1 + 2 + 2 * N_HID);
  localparam logic [ADDR_W-1:0] INPUT    = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_BIAS,
    S_WAIT,
    S_ACT,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_inc;

  function automatic logic [ADDR_W-1:0] weight_base(input logic [1:0] l);
    case (l)
      2'd1:    weight_base = WEIGHT_1;
      2'd2:    weight_base = WEIGHT_2;
      default: weight_base = WEIGHT_3;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] bias_base(input logic [1:0] l);
    case (l)
      2'd1:    bias_base = BIAS_1;
      2'd2:    bias_base = BIAS_2;
      default: bias_base = BIAS_3;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] last_idx(input logic [1:0] l);
    last_idx = (l == 2'd1) ? ADDR_W'(N_IN1 - 1) : ADDR_W'(N_HID - 1);
  endfunction

  assign idx_inc = idx + ADDR_W'(1);

  // Read strobes follow dp_ready in the same cycle so a stall never issues a read.
  assign wb_rd = dp_ready && ((state == S_STREAM) || (state == S_BIAS));
  assign in_rd = dp_ready && (state == S_STREAM) && (layer == 2'd1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      layer      <= 2'd0;
      wb_addr    <= '0;
      in_addr    <= '0;
      hid_idx    <= '0;
      mac_clear  <= 1'b0;
      mac_valid  <= 1'b0;
      bias_valid <= 1'b0;
      act_start  <= 1'b0;
    end else begin
      mac_clear  <= 1'b0;
      act_start  <= 1'b0;
      done       <= 1'b0;
      // One-cycle BRAM latency: valids are the previous cycle's reads, split by kind.
      mac_valid  <= dp_ready && (state == S_STREAM);
      bias_valid <= dp_ready && (state == S_BIAS);
      case (state)
        S_IDLE: begin
          if (start) begin
            layer     <= 2'd1;
            idx       <= '0;
            busy      <= 1'b1;
            mac_clear <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          idx     <= '0;
          wb_addr <= weight_base(layer);
          if (layer == 2'd1) in_addr <= INPUT;
          else               hid_idx <= '0;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (dp_ready) begin
            if (idx == last_idx(layer)) begin
              idx     <= '0;
              wb_addr <= bias_base(layer);
              state   <= S_BIAS;
            end else begin
              idx     <= idx_inc;
              wb_addr <= weight_base(layer) + idx_inc;
              if (layer == 2'd1) in_addr <= INPUT + idx_inc;
              else               hid_idx <= idx_inc[4:0];
            end
          end
        end
        S_BIAS: begin
          if (dp_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          // The output layer feeds argmax directly, so it skips the sigmoid stage.
          if (layer == 2'd3) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            act_start <= 1'b1;
            state     <= S_ACT;
          end
        end
        S_ACT: begin
          // act_start is high only on the entry cycle, where act_done is ignored.
          if (!act_start && act_done) begin
            layer     <= layer + 2'd1;
            mac_clear <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_DONE: begin
          layer <= 2'd0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          layer <= 2'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                      cycle_count <= '0;
    else if (state == S_IDLE && start) cycle_count <= '0;
    else if (busy)                     cycle_count <= sat_inc16(cycle_count);
  end
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: a read-list model built from the BRAM map
// checks every issued read and valid pulse; literal expectations pin latency and counts.
module tb_nn_layer_sequencer;
  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset_n, start, dp_ready, act_done;
  logic              busy, done, wb_rd, in_rd, mac_clear, mac_valid, bias_valid, act_start;
  logic [1:0]        layer;
  logic [ADDR_W-1:0] wb_addr, in_addr;
  logic [4:0]        hid_idx;
`ifdef SEQ_CYCLE_CNT_EN
  logic [15:0]       cycle_count;
`endif

  nn_layer_sequencer #(.N_IN1(784), .N_HID(20), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .dp_ready(dp_ready), .act_done(act_done),
    .busy(busy), .done(done), .layer(layer), .wb_addr(wb_addr), .wb_rd(wb_rd),
    .in_addr(in_addr), .in_rd(in_rd), .hid_idx(hid_idx), .mac_clear(mac_clear),
    .mac_valid(mac_valid), .bias_valid(bias_valid), .act_start(act_start)
`ifdef SEQ_CYCLE_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int addr;
    int lyr;
    bit is_bias;
    int idx;
  } rd_t;

  rd_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Per-pass observations, written by the compare process.
  bit  active = 0;
  int  t0 = 0, exp_lat = 838;
  int  n_mac = 0, n_bias = 0, n_act = 0, n_done = 0;
  int  first_wb = -1, first_in = -1, last_l1 = -1;
  int  l2_first_addr = -1, l2_first_hid = -1, l2_last_addr = -1, l2_last_hid = -1;
  int  bias_obs[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d (0x%0h), no such event allowed, at %0t", name, act, act, $time);
  endtask

  // The full read sequence of one pass, straight from the BRAM map.
  function automatic void build_model();
    int  wbase[3] = '{'h000, 'h311, 'h326};
    int  bbase[3] = '{'h310, 'h325, 'h33A};
    int  n[3]     = '{784, 20, 20};
    rd_t e;
    exp_q.delete();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < n[l]; i++) begin
        e.addr = wbase[l] + i; e.lyr = l + 1; e.is_bias = 1'b0; e.idx = i;
        exp_q.push_back(e);
      end
      e.addr = bbase[l]; e.lyr = l + 1; e.is_bias = 1'b1; e.idx = 0;
      exp_q.push_back(e);
    end
  endfunction

  initial begin : compare
    int  t;
    bit  prev_w, prev_b, seen_l2;
    rd_t e;
    t = 0; prev_w = 0; prev_b = 0; seen_l2 = 0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        active = 0; prev_w = 0; prev_b = 0;
        exp_q.delete();
      end else begin
        chk("mac_valid", mac_valid, prev_w);
        chk("bias_valid", bias_valid, prev_b);
        prev_w = 0; prev_b = 0;
        if (mac_valid)  n_mac++;
        if (bias_valid) n_bias++;
        if (act_start)  n_act++;
        if (!active && start && !busy && !done && layer == 2'd0) begin
          active = 1; t0 = t; build_model();
          n_mac = 0; n_bias = 0; n_act = 0; n_done = 0; seen_l2 = 0;
          first_wb = -1; first_in = -1; last_l1 = -1;
          bias_obs.delete();
        end
        if (wb_rd) begin
          chk("wb_rd_gated", dp_ready, 1);
          if (exp_q.size() == 0) fail("extra_read", wb_addr);
          else begin
            e = exp_q.pop_front();
            chk("wb_addr", wb_addr, e.addr);
            chk("layer", layer, e.lyr);
            chk("in_rd", in_rd, (e.lyr == 1 && !e.is_bias));
            if (e.lyr == 1 && !e.is_bias) chk("in_addr", in_addr, e.idx);
            else if (!e.is_bias)          chk("hid_idx", hid_idx, e.idx);
            prev_w = !e.is_bias;
            prev_b = e.is_bias;
            if (first_wb < 0) begin first_wb = wb_addr; first_in = in_addr; end
            if (e.is_bias) bias_obs.push_back(int'(wb_addr));
            else if (layer == 2'd1) last_l1 = wb_addr;
            else if (layer == 2'd2) begin
              if (!seen_l2) begin l2_first_addr = wb_addr; l2_first_hid = hid_idx; seen_l2 = 1; end
              l2_last_addr = wb_addr; l2_last_hid = hid_idx;
            end
          end
        end else begin
          chk("in_rd_without_wb_rd", in_rd, 0);
        end
        if (done) begin
          n_done++;
          chk("busy_at_done", busy, 0);
          chk("done_in_pass", active, 1);
          if (active) begin
            chk("done_latency", t - t0, exp_lat);
            chk("reads_left", exp_q.size(), 0);
          end
          active = 0;
        end
      end
      t++;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_layer"}, layer, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_in_addr"}, in_addr, 0);
    chk({tag, "_in_rd"}, in_rd, 0);
    chk({tag, "_hid_idx"}, hid_idx, 0);
    chk({tag, "_mac_clear"}, mac_clear, 0);
    chk({tag, "_mac_valid"}, mac_valid, 0);
    chk({tag, "_bias_valid"}, bias_valid, 0);
    chk({tag, "_act_start"}, act_start, 0);
`ifdef SEQ_CYCLE_CNT_EN
    chk({tag, "_cycle_count"}, cycle_count, 0);
`endif
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge Clk);
      if (done) ok = 1;
    end
    chk("done_seen", ok, 1);
    @(posedge Clk); #1;
  endtask

  task automatic wait_act(input int limit);
    bit ok;
    ok = 0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge Clk);
      if (act_start) ok = 1;
    end
    chk("act_start_seen", ok, 1);
  endtask

  task automatic chk_pass_counts(input string tag, input int cyc);
    chk({tag, "_mac_pulses"}, n_mac, 784 + 20 + 20);
    chk({tag, "_bias_pulses"}, n_bias, 3);
    chk({tag, "_act_pulses"}, n_act, 2);
    chk({tag, "_done_pulses"}, n_done, 1);
`ifdef SEQ_CYCLE_CNT_EN
    chk({tag, "_cycle_count"}, cycle_count, cyc);
`else
    chk({tag, "_cycle_ref"}, cyc + 1, exp_lat);
`endif
  endtask

  initial begin : main
    bit ok;
    Reset_n = 1'b0; start = 1'b0; dp_ready = 1'b1; act_done = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_zero("reset");
    @(posedge Clk); #1 Reset_n = 1'b1;

    // Nominal pass with literal address pins.
    exp_lat = 838;
    pulse_start();
    wait_done(1000);
    chk_pass_counts("nominal", 837);
    chk("first_wb_addr", first_wb, 'h000);
    chk("first_in_addr", first_in, 'h000);
    chk("last_l1_wb_addr", last_l1, 'h30F);
    chk("bias_count", bias_obs.size(), 3);
    for (int b = 0; b < bias_obs.size() && b < 3; b++)
      chk("bias_addr", bias_obs[b], (b == 0) ? 'h310 : (b == 1) ? 'h325 : 'h33A);
    chk("l2_first_addr", l2_first_addr, 'h311);
    chk("l2_first_hid", l2_first_hid, 0);
    chk("l2_last_addr", l2_last_addr, 'h324);
    chk("l2_last_hid", l2_last_hid, 19);
    @(negedge Clk);
    chk("idle_layer", layer, 0);
    chk("idle_busy", busy, 0);
`ifdef SEQ_CYCLE_CNT_EN
    chk("cycle_count_hold", cycle_count, 837);
`endif

    // Five-cycle dp_ready stall at layer-1 i=100.
    exp_lat = 843;
    pulse_start();
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge Clk);
      if (wb_rd && wb_addr == 10'd99) ok = 1;
    end
    chk("stall_point_seen", ok, 1);
    @(posedge Clk); #1 dp_ready = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      chk("stall_wb_rd", wb_rd, 0);
      chk("stall_in_rd", in_rd, 0);
      chk("stall_wb_addr", wb_addr, 'h064);
      chk("stall_in_addr", in_addr, 'h064);
    end
    @(posedge Clk); #1 dp_ready = 1'b1;
    @(negedge Clk);
    chk("resume_wb_rd", wb_rd, 1);
    chk("resume_wb_addr", wb_addr, 'h064);
    wait_done(1000);
    chk_pass_counts("stall", 842);

    // Sigmoid stage holds act_done low for 10 cycles after each act_start.
    exp_lat = 858;
    act_done = 1'b0;
    pulse_start();
    for (int l = 1; l <= 2; l++) begin
      wait_act(1000);
      chk("act_entry_layer", layer, l);
      @(posedge Clk); #1;
      repeat (10) begin
        @(negedge Clk);
        chk("act_wait_layer", layer, l);
        chk("act_wait_busy", busy, 1);
        @(posedge Clk); #1;
      end
      act_done = 1'b1;
      @(negedge Clk);
      chk("act_exit_layer", layer, l);
      @(posedge Clk); #1 act_done = 1'b0;
      @(negedge Clk);
      chk("act_next_layer", layer, l + 1);
    end
    wait_done(1000);
    act_done = 1'b1;
    chk_pass_counts("delayed", 857);

    // Abort during layer 2, then a clean pass.
    exp_lat = 838;
    pulse_start();
    ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge Clk);
      if (wb_rd && layer == 2'd2) ok = 1;
    end
    chk("abort_point_seen", ok, 1);
    repeat (3) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("abort_no_done", n_done, 0);
    chk("abort_idle_layer", layer, 0);
    pulse_start();
    wait_done(1000);
    chk_pass_counts("after_abort", 837);

    // start re-asserted while busy must not disturb the pass.
    exp_lat = 838;
    pulse_start();
    repeat (50) @(posedge Clk);
    #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge Clk);
      if (layer == 2'd2) ok = 1;
    end
    chk("rearm_layer2_seen", ok, 1);
    @(posedge Clk); #1 start = 1'b1;
    repeat (3) @(posedge Clk);
    #1 start = 1'b0;
    wait_done(1000);
    chk_pass_counts("rearm", 837);
    repeat (20) @(negedge Clk);
    chk("rearm_single_done", n_done, 1);
    chk("rearm_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Controls the three-layer MNIST network inference pass. For each neuron-row word it drives the weight/bias BRAM address and the input-operand address from the `BRAM_ADDRS` map. It marks when BRAM read data is valid for the MAC datapath. It also triggers the sigmoid stage between layers. The block sits between the top-level control (start/done) and the shared weight BRAM, input BRAM, hidden register file and MAC/activation datapath.

## Interface
- `N_IN1`, default 784: layer-1 input count. Layer-1 weight words run from `WEIGHT_1` to `WEIGHT_1+N_IN1-1`.
- `N_HID`, default 20: input count for layers 2 and 3, i.e. the hidden width.
- `ADDR_W`, default 10: width of the BRAM address buses.

Ports:
- `Clk`, in, 1: single clock. All state changes on the rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request one inference. Sampled only in IDLE.
- `dp_ready`, in, 1: datapath can accept an operand. Low stalls streaming.
- `act_done`, in, 1: sigmoid stage has finished the current layer.
- `busy`, out, 1: inference in progress.
- `done`, out, 1: one-cycle pulse when inference is complete.
- `layer`, out, 2: current layer, 1–3. Value is 0 in IDLE.
- `wb_addr`, out, ADDR_W: weight/bias BRAM address.
- `wb_rd`, out, 1: weight/bias read strobe.
- `in_addr`, out, ADDR_W: input BRAM address. Used in layer 1 only.
- `in_rd`, out, 1: input BRAM read strobe.
- `hid_idx`, out, 5: hidden register select. Used in layers 2 and 3.
- `mac_clear`, out, 1: clear the accumulators.
- `mac_valid`, out, 1: operands on the BRAM/regfile outputs are valid this cycle.
- `bias_valid`, out, 1: bias word is valid this cycle.
- `act_start`, out, 1: one-cycle pulse that starts the sigmoid stage (LUT base `SIGMOID`).
- `cycle_count`, out, 16: present only with `SEQ_CYCLE_CNT_EN`.

## Operation
- States: IDLE → CLEAR → STREAM → BIAS → WAIT → ACT, then either back to CLEAR for the next layer or to DONE → IDLE.
- IDLE
  - `start`=1 sets `layer`=1 and the index `i`=0, then moves to CLEAR.
  - `start` is ignored in every other state.
- CLEAR: lasts one cycle. `mac_clear`=1. Moves to STREAM.
- STREAM, a cycle with `dp_ready`=1:
  - `wb_rd`=1 and `wb_addr` = WEIGHT_L + i, where WEIGHT_L is `WEIGHT_1`, `WEIGHT_2` or `WEIGHT_3`.
  - Layer 1: `in_rd`=1, `in_addr` = `INPUT` + i.
  - Layers 2 and 3: `in_rd`=0, `hid_idx` = i.
  - i increments. When i = N−1 the state moves to BIAS and i resets to 0. N is `N_IN1` for layer 1 and `N_HID` for layers 2 and 3.
- STREAM or BIAS, a cycle with `dp_ready`=0: strobes are 0 and addresses and i hold.
- BIAS, a cycle with `dp_ready`=1: `wb_rd`=1, `wb_addr` = BIAS_L (`BIAS_1`, `BIAS_2` or `BIAS_3`). Moves to WAIT.
- WAIT: lasts one cycle so the bias read can return.
  - Layers 1 and 2: next state is ACT.
  - Layer 3: next state is DONE (no activation; the argmax stage is downstream).
- ACT
  - `act_start`=1 on the entry cycle only. `act_done` is ignored in that cycle.
  - Leaves on the first later cycle that samples `act_done`=1. `layer` increments and the state moves to CLEAR.
- DONE: lasts one cycle. `done`=1, `busy`=0. Moves to IDLE.
- `busy` is 1 in every state except IDLE and DONE.
- Address arithmetic is an unsigned ADDR_W-bit add of base + i. It never wraps within the configured sizes.

## Timing
- BRAM read latency is 1 cycle.
  - `mac_valid` is `wb_rd` delayed one cycle, for STREAM-issued reads only.
  - `bias_valid` is the BIAS-issued `wb_rd` delayed one cycle.
- Every `mac_valid` is therefore high at least one cycle before `bias_valid`.
- A `dp_ready` gap creates a matching gap in `mac_valid`. No read is issued twice.
- Reset values: state IDLE and every output 0, including the address buses, `layer`, `hid_idx` and `cycle_count`.
- Reset asserted mid-pass aborts immediately to IDLE. No `done` is produced.
- Nominal latency, with `dp_ready`=1 and `act_done` tied high (ACT lasts 2 cycles), counting from the cycle that samples `start` as cycle 0:
  - layer 1 occupies cycles 1–789;
  - layer 2 occupies cycles 790–814;
  - layer 3 occupies cycles 815–837;
  - `done` pulses on cycle 838.

## Configuration
- `SEQ_CYCLE_CNT_EN` defined:
  - `cycle_count` exists.
  - It clears when `start` is accepted and increments on every cycle with `busy`=1, saturating at 16'hFFFF.
  - It holds its value after `done` until the next accepted `start`.
- `SEQ_CYCLE_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Nominal pass: reset, `start` pulse, `dp_ready`=1, `act_done`=1.
  - `done` on cycle 838.
  - Exactly 784 + 20 + 20 `mac_valid` pulses and 3 `bias_valid` pulses.
  - 2 `act_start` pulses.
  - `cycle_count`=837.
- Address check over the same pass:
  - first layer-1 read: `wb_addr`=0x000, `in_addr`=0x000;
  - last layer-1 read: `wb_addr`=0x30F;
  - bias reads: 0x310, 0x325, 0x33A;
  - layer-2 `wb_addr` runs 0x311–0x324 with `hid_idx` 0–19.
- Stall: drop `dp_ready` for 5 cycles at layer-1 i=100. `wb_addr` holds at 0x064 with no strobes, then resumes at 0x064. `done` moves to cycle 843.
- Delayed activation: hold `act_done` low for 10 cycles after each `act_start`. `layer` stays at 1, then 2, for the whole wait. `done` moves by 20 cycles.
- Abort: assert `Reset_n`=0 during layer 2. All outputs are 0 asynchronously, with no `done`. A new `start` completes a full pass.
- `start` re-asserted while `busy`: ignored. The address sequence is unchanged and exactly one `done` occurs.
